// File: rtl/chdr_insert_header.sv
// chdr_insert_header
//   Converts a headerless payload stream back into CHDR by prepending a
//   header word (and, on a 64-bit bus, a separate timestamp word for
//   DATA_TS packets). Payload words pass through combinationally with no
//   buffering; only the inserted words cost extra beats.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   insert_en            1 = prepend header, 0 = input is already CHDR
//   hdr_*                header fields, sampled while the header beat is presented
//   s_tdata/s_tuser/s_tlast/s_tvalid/s_tready
//                        payload stream in (s_tuser = payload bytes, first word)
//   m_chdr_tdata/m_chdr_tlast/m_chdr_tvalid/m_chdr_tready
//                        CHDR stream out
module chdr_insert_header #(
  parameter int CHDR_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              insert_en,
  input  logic [5:0]        hdr_vc,
  input  logic              hdr_eob,
  input  logic              hdr_eov,
  input  logic [2:0]        hdr_pkt_type,
  input  logic [15:0]       hdr_seq_num,
  input  logic [15:0]       hdr_dst_epid,
  input  logic [63:0]       hdr_timestamp,
  input  logic [CHDR_W-1:0] s_tdata,
  input  logic [15:0]       s_tuser,
  input  logic              s_tlast,
  input  logic              s_tvalid,
  output logic              s_tready,
  output logic [CHDR_W-1:0] m_chdr_tdata,
  output logic              m_chdr_tlast,
  output logic              m_chdr_tvalid,
  input  logic              m_chdr_tready
);

  localparam logic [2:0]  PKT_DATA_TS = 3'h7;
  localparam logic [15:0] BEAT_BYTES  = 16'(CHDR_W / 8);
  localparam bit          NARROW      = (CHDR_W == 64);

  typedef enum logic [1:0] {ST_HDR, ST_TS, ST_PASS} state_t;

  state_t      state;
  logic [63:0] ts_latched;

  logic        is_ts;
  logic [15:0] length;
  logic [63:0] hdr_word;
  logic [63:0] hdr_upper;
  logic [CHDR_W-1:0] hdr_full;
  logic [CHDR_W-1:0] ts_full;
  logic        out_hs;

  assign is_ts = (hdr_pkt_type == PKT_DATA_TS);

  // Length counts the whole CHDR packet: payload + header beat, plus the
  // extra timestamp beat on a 64-bit bus. Wraps modulo 2^16.
  assign length = s_tuser + BEAT_BYTES + ((NARROW && is_ts) ? 16'd8 : 16'd0);

  assign hdr_word = {hdr_vc, hdr_eob, hdr_eov, hdr_pkt_type, 5'd0,
                     hdr_seq_num, length, hdr_dst_epid};

  // On wide buses the timestamp rides in the header beat's upper half.
  assign hdr_upper = (!NARROW && is_ts) ? hdr_timestamp : 64'd0;
  assign hdr_full  = CHDR_W'({hdr_upper, hdr_word});
  assign ts_full   = CHDR_W'(ts_latched);

  always_comb begin
    m_chdr_tdata  = s_tdata;
    m_chdr_tlast  = s_tlast;
    m_chdr_tvalid = s_tvalid;
    s_tready      = m_chdr_tready;
    case (state)
      ST_HDR: begin
        if (insert_en) begin
          // Header beat is offered only once the first payload word is
          // present, since the length comes from its s_tuser.
          m_chdr_tdata = hdr_full;
          m_chdr_tlast = 1'b0;
          s_tready     = 1'b0;
        end
      end
      ST_TS: begin
        m_chdr_tvalid = 1'b1;
        m_chdr_tdata  = ts_full;
        m_chdr_tlast  = 1'b0;
        s_tready      = 1'b0;
      end
      default: ;
    endcase
    if (!rst_n) begin
      m_chdr_tvalid = 1'b0;
      m_chdr_tlast  = 1'b0;
      s_tready      = 1'b0;
    end
  end

  assign out_hs = m_chdr_tvalid && m_chdr_tready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_HDR;
      ts_latched <= 64'd0;
    end else begin
      case (state)
        ST_HDR: begin
          if (out_hs) begin
            if (insert_en) begin
              ts_latched <= hdr_timestamp;
              state      <= (NARROW && is_ts) ? ST_TS : ST_PASS;
            end else if (!s_tlast) begin
              state <= ST_PASS;
            end
          end
        end
        ST_TS: begin
          if (out_hs) state <= ST_PASS;
        end
        ST_PASS: begin
          if (out_hs && s_tlast) state <= ST_HDR;
        end
        default: state <= ST_HDR;
      endcase
    end
  end

endmodule

// File: tb/tb_chdr_insert_header.sv
module tb_chdr_insert_header;

  typedef struct {
    logic [127:0] data;
    logic         last;
    logic [15:0]  user;
    logic         ins;
    logic [5:0]   vc;
    logic         eob;
    logic         eov;
    logic [2:0]   typ;
    logic [15:0]  seq;
    logic [15:0]  epid;
    logic [63:0]  ts;
  } word_t;

  typedef struct {
    logic [127:0] data;
    logic         last;
    logic         sready;
    int           cyc;
  } beat_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         sel;
  logic         insert_en;
  logic [5:0]   hdr_vc;
  logic         hdr_eob, hdr_eov;
  logic [2:0]   hdr_pkt_type;
  logic [15:0]  hdr_seq_num, hdr_dst_epid;
  logic [63:0]  hdr_timestamp;
  logic [127:0] s_tdata;
  logic [15:0]  s_tuser;
  logic         s_tlast, s_tvalid, m_tready;

  logic         s_tvalid_a, s_tvalid_b, m_tready_a, m_tready_b;
  logic         s_tready_a, s_tready_b;
  logic [63:0]  m_tdata_a;
  logic [127:0] m_tdata_b;
  logic         m_tlast_a, m_tlast_b, m_tvalid_a, m_tvalid_b;

  logic         mux_valid, mux_last, mux_sready;
  logic [127:0] mux_data;

  int    n_cmp = 0;
  int    n_fail = 0;
  int    cyc_count = 0;
  bit    src_hold = 0;
  word_t src_q[$];
  beat_t out_q[$];

  always #5 clk = ~clk;

  // Only the selected instance sees traffic; the other idles in its header state.
  assign s_tvalid_a = s_tvalid & ~sel;
  assign s_tvalid_b = s_tvalid & sel;
  assign m_tready_a = m_tready & ~sel;
  assign m_tready_b = m_tready & sel;
  assign mux_valid  = sel ? m_tvalid_b : m_tvalid_a;
  assign mux_last   = sel ? m_tlast_b : m_tlast_a;
  assign mux_sready = sel ? s_tready_b : s_tready_a;
  assign mux_data   = sel ? m_tdata_b : {64'd0, m_tdata_a};

  chdr_insert_header #(.CHDR_W(64)) dut_a (
    .clk(clk), .rst_n(rst_n), .insert_en(insert_en),
    .hdr_vc(hdr_vc), .hdr_eob(hdr_eob), .hdr_eov(hdr_eov),
    .hdr_pkt_type(hdr_pkt_type), .hdr_seq_num(hdr_seq_num),
    .hdr_dst_epid(hdr_dst_epid), .hdr_timestamp(hdr_timestamp),
    .s_tdata(s_tdata[63:0]), .s_tuser(s_tuser), .s_tlast(s_tlast),
    .s_tvalid(s_tvalid_a), .s_tready(s_tready_a),
    .m_chdr_tdata(m_tdata_a), .m_chdr_tlast(m_tlast_a),
    .m_chdr_tvalid(m_tvalid_a), .m_chdr_tready(m_tready_a)
  );

  chdr_insert_header #(.CHDR_W(128)) dut_b (
    .clk(clk), .rst_n(rst_n), .insert_en(insert_en),
    .hdr_vc(hdr_vc), .hdr_eob(hdr_eob), .hdr_eov(hdr_eov),
    .hdr_pkt_type(hdr_pkt_type), .hdr_seq_num(hdr_seq_num),
    .hdr_dst_epid(hdr_dst_epid), .hdr_timestamp(hdr_timestamp),
    .s_tdata(s_tdata), .s_tuser(s_tuser), .s_tlast(s_tlast),
    .s_tvalid(s_tvalid_b), .s_tready(s_tready_b),
    .m_chdr_tdata(m_tdata_b), .m_chdr_tlast(m_tlast_b),
    .m_chdr_tvalid(m_tvalid_b), .m_chdr_tready(m_tready_b)
  );

  function automatic logic [63:0] mk_hdr(input logic [5:0] vc, input logic eob,
      input logic eov, input logic [2:0] typ, input logic [15:0] seq,
      input logic [15:0] len, input logic [15:0] epid);
    return {vc, eob, eov, typ, 5'd0, seq, len, epid};
  endfunction

  task automatic push_pkt(input logic ins, input logic [5:0] vc, input logic eob,
      input logic eov, input logic [2:0] typ, input logic [15:0] seq,
      input logic [15:0] epid, input logic [63:0] ts, input int nwords,
      input logic [127:0] base, input logic [15:0] user);
    word_t w;
    for (int i = 0; i < nwords; i++) begin
      w.data = base + 128'(i); w.last = (i == nwords - 1); w.user = user;
      w.ins = ins; w.vc = vc; w.eob = eob; w.eov = eov; w.typ = typ;
      w.seq = seq; w.epid = epid; w.ts = ts;
      src_q.push_back(w);
    end
  endtask

  // One clock of stimulus; called at posedge+1, returns at the next posedge+1.
  task automatic step(input bit want_valid, input bit want_ready,
      output bit o_valid, output logic [127:0] o_data, output bit o_last);
    word_t w;
    beat_t b;
    bit    in_hs;
    if (src_q.size() > 0) begin
      w = src_q[0];
      s_tdata = w.data; s_tlast = w.last; s_tuser = w.user; insert_en = w.ins;
      hdr_vc = w.vc; hdr_eob = w.eob; hdr_eov = w.eov; hdr_pkt_type = w.typ;
      hdr_seq_num = w.seq; hdr_dst_epid = w.epid; hdr_timestamp = w.ts;
      s_tvalid = want_valid | src_hold;
    end else begin
      s_tvalid = 1'b0;
    end
    m_tready = want_ready;
    @(negedge clk);
    o_valid = mux_valid; o_data = mux_data; o_last = mux_last;
    if (mux_valid && m_tready) begin
      b.data = mux_data; b.last = mux_last; b.sready = mux_sready; b.cyc = cyc_count;
      out_q.push_back(b);
    end
    in_hs = s_tvalid && mux_sready;
    src_hold = s_tvalid && !mux_sready;
    if (in_hs) w = src_q.pop_front();
    @(posedge clk);
    #1;
    cyc_count++;
  endtask

  task automatic run_until(input int n_beats, input int budget, output bit timed_out);
    bit v, l;
    logic [127:0] d;
    int c = 0;
    while (out_q.size() < n_beats && c < budget) begin
      step(1'b1, 1'b1, v, d, l);
      c++;
    end
    timed_out = (out_q.size() < n_beats);
  endtask

  task automatic test_reset();
    s_tvalid = 1'b1; m_tready = 1'b1; insert_en = 1'b0; s_tlast = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (m_tvalid_a !== 1'b0 || s_tready_a !== 1'b0 || m_tlast_a !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_a: tvalid=%b tready=%b tlast=%b required 0 0 0", m_tvalid_a, s_tready_a, m_tlast_a);
    end
    n_cmp++;
    if (m_tvalid_b !== 1'b0 || s_tready_b !== 1'b0 || m_tlast_b !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_b: tvalid=%b tready=%b tlast=%b required 0 0 0", m_tvalid_b, s_tready_b, m_tlast_b);
    end
    @(posedge clk); #1;
    s_tvalid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    $display("reset: checked outputs held low");
  endtask

  task automatic test_no_ts();
    bit to;
    logic [63:0] exp_d [4];
    sel = 1'b0; out_q.delete(); src_hold = 0;
    push_pkt(1'b1, 6'd0, 1'b0, 1'b0, 3'h6, 16'd5, 16'h0012, 64'd0, 3, 128'hA000, 16'd24);
    run_until(4, 50, to);
    n_cmp++;
    if (to) begin n_fail++; $display("FAIL no_ts_timeout: beats=%0d required 4", out_q.size()); end
    exp_d[0] = 64'h00C0_0005_0020_0012;
    exp_d[1] = 64'hA000; exp_d[2] = 64'hA001; exp_d[3] = 64'hA002;
    for (int i = 0; i < 4 && i < out_q.size(); i++) begin
      n_cmp++;
      if (out_q[i].data[63:0] !== exp_d[i] || out_q[i].last !== (i == 3)) begin
        n_fail++;
        $display("FAIL no_ts_beat%0d: data=%h last=%b required %h %b", i, out_q[i].data[63:0], out_q[i].last, exp_d[i], (i == 3));
      end
    end
    $display("no_ts: %0d output beats", out_q.size());
  endtask

  task automatic test_ts();
    bit to;
    logic [63:0] exp_d [3];
    logic        exp_r [3];
    sel = 1'b0; out_q.delete(); src_hold = 0;
    push_pkt(1'b1, 6'd0, 1'b0, 1'b0, 3'h7, 16'd6, 16'h0034, 64'h1122334455667788, 1, 128'hBEEF, 16'd8);
    run_until(3, 50, to);
    n_cmp++;
    if (to) begin n_fail++; $display("FAIL ts_timeout: beats=%0d required 3", out_q.size()); end
    exp_d[0] = 64'h00E0_0006_0018_0034; exp_d[1] = 64'h1122334455667788; exp_d[2] = 64'hBEEF;
    exp_r[0] = 1'b0; exp_r[1] = 1'b0; exp_r[2] = 1'b1;
    for (int i = 0; i < 3 && i < out_q.size(); i++) begin
      n_cmp++;
      if (out_q[i].data[63:0] !== exp_d[i] || out_q[i].last !== (i == 2) || out_q[i].sready !== exp_r[i]) begin
        n_fail++;
        $display("FAIL ts_beat%0d: data=%h last=%b s_tready=%b required %h %b %b", i,
                 out_q[i].data[63:0], out_q[i].last, out_q[i].sready, exp_d[i], (i == 2), exp_r[i]);
      end
    end
    $display("ts: %0d output beats", out_q.size());
  endtask

  task automatic test_w128();
    bit to;
    logic [127:0] exp_d [3];
    sel = 1'b1; out_q.delete(); src_hold = 0;
    push_pkt(1'b1, 6'd3, 1'b1, 1'b0, 3'h7, 16'd7, 16'h0056, 64'h1122334455667788, 2,
             128'h5555_0000_0000_0000_0000_0000_0000_0010, 16'd32);
    run_until(3, 50, to);
    n_cmp++;
    if (to) begin n_fail++; $display("FAIL w128_timeout: beats=%0d required 3", out_q.size()); end
    exp_d[0] = 128'h1122334455667788_0EE0000700300056;
    exp_d[1] = 128'h5555_0000_0000_0000_0000_0000_0000_0010;
    exp_d[2] = 128'h5555_0000_0000_0000_0000_0000_0000_0011;
    for (int i = 0; i < 3 && i < out_q.size(); i++) begin
      n_cmp++;
      if (out_q[i].data !== exp_d[i] || out_q[i].last !== (i == 2)) begin
        n_fail++;
        $display("FAIL w128_beat%0d: data=%h last=%b required %h %b", i, out_q[i].data, out_q[i].last, exp_d[i], (i == 2));
      end
    end
    sel = 1'b0;
    $display("w128: %0d output beats", out_q.size());
  endtask

  task automatic test_back_to_back();
    bit to;
    logic [63:0] exp_d [6];
    logic        exp_l [6];
    sel = 1'b0; out_q.delete(); src_hold = 0;
    push_pkt(1'b0, 6'd0, 1'b0, 1'b0, 3'h6, 16'd0, 16'd0, 64'd0, 3, 128'hC0DE_0000, 16'd0);
    push_pkt(1'b1, 6'd1, 1'b0, 1'b1, 3'h6, 16'd9, 16'h0078, 64'd0, 2, 128'hD000, 16'd16);
    run_until(6, 50, to);
    n_cmp++;
    if (to) begin n_fail++; $display("FAIL b2b_timeout: beats=%0d required 6", out_q.size()); end
    exp_d[0] = 64'hC0DE_0000; exp_d[1] = 64'hC0DE_0001; exp_d[2] = 64'hC0DE_0002;
    exp_d[3] = 64'h05C0_0009_0018_0078; exp_d[4] = 64'hD000; exp_d[5] = 64'hD001;
    exp_l[0] = 0; exp_l[1] = 0; exp_l[2] = 1; exp_l[3] = 0; exp_l[4] = 0; exp_l[5] = 1;
    for (int i = 0; i < 6 && i < out_q.size(); i++) begin
      n_cmp++;
      if (out_q[i].data[63:0] !== exp_d[i] || out_q[i].last !== exp_l[i] ||
          out_q[i].cyc !== out_q[0].cyc + i) begin
        n_fail++;
        $display("FAIL b2b_beat%0d: data=%h last=%b cycle=%0d required %h %b %0d", i,
                 out_q[i].data[63:0], out_q[i].last, out_q[i].cyc, exp_d[i], exp_l[i], out_q[0].cyc + i);
      end
    end
    $display("back_to_back: %0d output beats", out_q.size());
  endtask

  task automatic test_random();
    logic [63:0] exp_q[$];
    logic        expl_q[$];
    bit          v, l, prev_stall;
    logic [127:0] d, prev_d;
    bit          prev_l;
    int          c, n_beats;
    sel = 1'b0; out_q.delete(); src_hold = 0; prev_stall = 0; prev_d = '0; prev_l = 0;
    for (int p = 0; p < 1000; p++) begin
      logic        ins;
      logic [2:0]  typ;
      logic [5:0]  vc;
      logic [15:0] seq, epid, user, len;
      logic [63:0] ts;
      logic [127:0] base;
      int nw;
      ins = ($urandom_range(0, 4) != 0);
      typ = ($urandom_range(0, 1) != 0) ? 3'h7 : 3'h6;
      vc = 6'($urandom); seq = 16'(p); epid = 16'($urandom);
      ts = {$urandom, $urandom}; base = 128'({$urandom, 16'h0000});
      nw = $urandom_range(1, 4);
      user = ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'(nw * 8);
      len = user + 16'd8 + ((typ == 3'h7) ? 16'd8 : 16'd0);
      push_pkt(ins, vc, 1'b0, 1'b1, typ, seq, epid, ts, nw, base, user);
      if (ins) begin
        exp_q.push_back(mk_hdr(vc, 1'b0, 1'b1, typ, seq, len, epid)); expl_q.push_back(1'b0);
        if (typ == 3'h7) begin exp_q.push_back(ts); expl_q.push_back(1'b0); end
      end
      for (int i = 0; i < nw; i++) begin
        exp_q.push_back(base[63:0] + 64'(i)); expl_q.push_back(i == nw - 1);
      end
    end
    c = 0; n_beats = 0;
    while ((src_q.size() > 0 || out_q.size() > 0) && c < 40000) begin
      step($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 50, v, d, l);
      c++;
      if (prev_stall) begin
        n_cmp++;
        if (v !== 1'b1 || d !== prev_d || l !== prev_l) begin
          n_fail++;
          $display("FAIL rand_stable cyc=%0d: valid=%b data=%h last=%b required 1 %h %b", c, v, d[63:0], l, prev_d[63:0], prev_l);
        end
      end
      prev_stall = v && !m_tready; prev_d = d; prev_l = l;
      while (out_q.size() > 0) begin
        beat_t b;
        b = out_q.pop_front();
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL rand_extra_beat: data=%h required no beat", b.data[63:0]);
        end else begin
          logic [63:0] e;
          logic el;
          e = exp_q.pop_front(); el = expl_q.pop_front();
          if (b.data[63:0] !== e || b.last !== el) begin
            n_fail++;
            $display("FAIL rand_beat%0d: data=%h last=%b required %h %b", n_beats, b.data[63:0], b.last, e, el);
          end
        end
        n_beats++;
      end
    end
    n_cmp++;
    if (exp_q.size() != 0 || src_q.size() != 0) begin
      n_fail++;
      $display("FAIL rand_drain: missing beats=%0d pending words=%0d required 0 0", exp_q.size(), src_q.size());
    end
    src_q.delete();
    $display("random: %0d beats over %0d cycles", n_beats, c);
  endtask

  task automatic test_mid_reset();
    bit to;
    sel = 1'b0; out_q.delete(); src_hold = 0;
    push_pkt(1'b1, 6'd0, 1'b0, 1'b0, 3'h6, 16'd2, 16'h0002, 64'd0, 3, 128'hE000, 16'd24);
    run_until(2, 50, to);
    n_cmp++;
    if (to) begin n_fail++; $display("FAIL mrst_pre_timeout: beats=%0d required 2", out_q.size()); end
    rst_n = 1'b0;
    s_tvalid = 1'b1; m_tready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_cmp++;
      if (m_tvalid_a !== 1'b0 || s_tready_a !== 1'b0) begin
        n_fail++;
        $display("FAIL mrst_hold%0d: tvalid=%b tready=%b required 0 0", k, m_tvalid_a, s_tready_a);
      end
      @(posedge clk); #1;
    end
    s_tvalid = 1'b0;
    rst_n = 1'b1;
    src_q.delete(); out_q.delete(); src_hold = 0;
    push_pkt(1'b1, 6'd0, 1'b0, 1'b0, 3'h6, 16'h0011, 16'h0099, 64'd0, 1, 128'hF00D, 16'd8);
    run_until(2, 50, to);
    n_cmp++;
    if (to) begin n_fail++; $display("FAIL mrst_post_timeout: beats=%0d required 2", out_q.size()); end
    if (out_q.size() >= 2) begin
      n_cmp++;
      if (out_q[0].data[63:0] !== 64'h00C0_0011_0010_0099 || out_q[0].last !== 1'b0) begin
        n_fail++;
        $display("FAIL mrst_hdr: data=%h last=%b required 00c0001100100099 0", out_q[0].data[63:0], out_q[0].last);
      end
      n_cmp++;
      if (out_q[1].data[63:0] !== 64'hF00D || out_q[1].last !== 1'b1) begin
        n_fail++;
        $display("FAIL mrst_payload: data=%h last=%b required 000000000000f00d 1", out_q[1].data[63:0], out_q[1].last);
      end
    end
    $display("mid_reset: %0d output beats after release", out_q.size());
  endtask

  initial begin
    rst_n = 1'b0; sel = 1'b0; insert_en = 1'b0;
    hdr_vc = '0; hdr_eob = 0; hdr_eov = 0; hdr_pkt_type = '0; hdr_seq_num = '0;
    hdr_dst_epid = '0; hdr_timestamp = '0; s_tdata = '0; s_tuser = '0;
    s_tlast = 0; s_tvalid = 0; m_tready = 0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_no_ts();
    test_ts();
    test_w128();
    test_back_to_back();
    test_random();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
